keypad_scan: RTL and testbench

Scanned 4x4 matrix-keypad reader for the FPGA board I/O layer. This is the input-side counterpart of the multiplexed LED display driver. It drives one active-low column at a time, samples the four active-low row lines, debounces across whole scan frames, and reports a single key code with a one-cycle press strobe to the MIPS I/O logic.

---
 rtl/keypad_scan_if.sv | 12 +
 rtl/keypad_scan.sv | 193 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// Keypad scanner signal bundle: matrix row/column lines plus the decoded key outputs.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scan_if;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] KEYCODE;
    logic       KEYVALID;
    logic       KEYHELD;

    modport master (input ROW, output COL, KEYCODE, KEYVALID, KEYHELD);
    modport slave  (output ROW, input COL, KEYCODE, KEYVALID, KEYHELD);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame-level debounce and a one-cycle press strobe.
// Optional macro KEYPAD_GHOST_REJECT_EN: frames with two or more keys down count as no-hit.
module keypad_scan #(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);

    localparam int unsigned TW = $clog2(SCAN_DIV);
    localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LIM = CW'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_t;

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [TW-1:0] timer;
    logic [1:0]    col_idx;

    logic          acc_valid;
    logic [3:0]    acc_code;
    logic [4:0]    acc_cnt;

    state_t        state;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    key_code;
    logic          key_valid;
    logic          key_held;

    logic          sample;
    logic          frame_end;
    logic          col_hit;
    logic [1:0]    row_idx;
    logic [2:0]    col_keys;
    logic          found;
    logic [3:0]    frame_code;
    logic [4:0]    frame_cnt;
    logic          frame_hit;

    assign sample    = (timer == T_LAST);
    assign frame_end = sample && (col_idx == 2'd3);
    assign col_hit   = ~&row_sync;
    assign cnt_inc   = cnt + 1'b1;

    always_comb begin
        row_idx  = '0;
        col_keys = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!row_sync[i]) begin
                col_keys = col_keys + 3'd1;
                if (!found) begin
                    row_idx = 2'(i);
                    found   = 1'b1;
                end
            end
        end
    end

    // The current column's sample is folded in so the column-3 sample completes the frame.
    always_comb begin
        frame_code = acc_valid ? acc_code : {col_idx, row_idx};
        frame_cnt  = sample ? (acc_cnt + {2'b00, col_keys}) : acc_cnt;
`ifdef KEYPAD_GHOST_REJECT_EN
        frame_hit  = (frame_cnt == 5'd1);
`else
        frame_hit  = (frame_cnt != 5'd0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta  <= '1;
            row_sync  <= '1;
            timer     <= '0;
            col_idx   <= '0;
            acc_valid <= 1'b0;
            acc_code  <= '0;
            acc_cnt   <= '0;
        end else begin
            row_meta <= kp.ROW;
            row_sync <= row_meta;
            if (sample) begin
                timer   <= '0;
                col_idx <= col_idx + 2'd1;
                if (col_idx == 2'd3) begin
                    acc_valid <= 1'b0;
                    acc_code  <= '0;
                    acc_cnt   <= '0;
                end else begin
                    acc_cnt <= frame_cnt;
                    if (col_hit && !acc_valid) begin
                        acc_valid <= 1'b1;
                        acc_code  <= {col_idx, row_idx};
                    end
                end
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                case (state)
                    IDLE: begin
                        if (frame_hit) begin
                            if (DEBOUNCE_FRAMES == 1) begin
                                state     <= HELD;
                                key_code  <= frame_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= '0;
                            end else begin
                                state <= PRESS_CHK;
                                cand  <= frame_code;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    PRESS_CHK: begin
                        if (!frame_hit) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (frame_code != cand) begin
                            cand <= frame_code;
                            cnt  <= CW'(1);
                        end else if (cnt_inc == CNT_LIM) begin
                            state     <= HELD;
                            key_code  <= cand;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    HELD: begin
                        if (!frame_hit) begin
                            if (DEBOUNCE_FRAMES == 1) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                                cnt      <= '0;
                            end else begin
                                state <= RELEASE_CHK;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    RELEASE_CHK: begin
                        if (frame_hit) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt_inc == CNT_LIM) begin
                            state    <= IDLE;
                            key_held <= 1'b0;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign kp.COL      = ~(4'b0001 << col_idx);
    assign kp.KEYCODE  = key_code;
    assign kp.KEYVALID = key_valid;
    assign kp.KEYHELD  = key_held;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_FRAMES=2) with a matrix keypad model.
module tb_keypad_scan;

    localparam int unsigned SD    = 4;
    localparam int unsigned DF    = 2;
    localparam int unsigned FRAME = 4 * SD;

    typedef struct {
        logic [3:0]  code;
        int unsigned cycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0;
    logic [3:0]  row_model;
    int unsigned cyc;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    logic        prev_valid = 1'b0;
    exp_t        sb[$];
    exp_t        e;

    keypad_scan_if kif();

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif.master)
    );

    always #5 clk = ~clk;

    // Pressed key at code {col,row} pulls its row low while its column is driven low.
    always_comb begin
        row_model = 4'hF;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                if (!kif.COL[c] && keys[c*4 + r]) row_model[r] = 1'b0;
    end
    assign kif.ROW = row_model;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_valid) check("valid_pulse_width", kif.KEYVALID, 0);
            if (kif.KEYVALID) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", kif.KEYVALID, 0);
                end else begin
                    e = sb.pop_front();
                    check("keycode", kif.KEYCODE, e.code);
                    check("valid_cycle", cyc, e.cycle);
                    check("held_with_valid", kif.KEYHELD, 1);
                end
            end
        end
        prev_valid = kif.KEYVALID && !rst;
    end

    task automatic frames(input int unsigned n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    task automatic expect_press(input logic [3:0] code);
        exp_t x;
        x.code  = code;
        x.cycle = cyc + DF * FRAME;
        sb.push_back(x);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"},   kif.COL, 4'b1110);
        check({tag, "_code"},  kif.KEYCODE, 4'h0);
        check({tag, "_valid"}, kif.KEYVALID, 0);
        check({tag, "_held"},  kif.KEYHELD, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ec;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Idle scan: one-hot-low column rotation, 4 cycles per column
        for (int unsigned i = 0; i < 64; i++) begin
            ec = ~(4'b0001 << ((i / SD) % 4));
            check("col_rotation", kif.COL, ec);
            @(negedge clk);
        end
        check("idle_held", kif.KEYHELD, 0);

        // Long press of col 2 row 1, then release
        keys = 16'h0200;
        expect_press(4'h9);
        frames(10);
        check("press9_held", kif.KEYHELD, 1);
        check("press9_code", kif.KEYCODE, 4'h9);
        keys = '0;
        repeat (2 * FRAME - 1) @(negedge clk);
        check("release_before_edge", kif.KEYHELD, 1);
        @(negedge clk);
        check("release_edge", kif.KEYHELD, 0);
        check("code_retained", kif.KEYCODE, 4'h9);

        // Bouncing col 0 row 3, then steady
        for (int unsigned f = 0; f < 6; f++) begin
            keys = (f % 2 == 0) ? 16'h0008 : 16'h0000;
            frames(1);
        end
        check("bounce_no_held", kif.KEYHELD, 0);
        keys = 16'h0008;
        expect_press(4'h3);
        frames(4);
        check("steady3_code", kif.KEYCODE, 4'h3);
        keys = '0;
        frames(2);
        check("release3_held", kif.KEYHELD, 0);

        // Single-frame dropout while held must not retrigger
        keys = 16'h0200;
        expect_press(4'h9);
        frames(3);
        keys = '0;
        frames(1);
        check("dropout_held", kif.KEYHELD, 1);
        keys = 16'h0200;
        frames(3);
        check("return_held", kif.KEYHELD, 1);
        check("return_code", kif.KEYCODE, 4'h9);
        keys = '0;
        frames(2);

        // Two keys together: 4'h5 (col1,row1) and 4'hE (col3,row2)
        keys = 16'h4020;
`ifndef KEYPAD_GHOST_REJECT_EN
        expect_press(4'h5);
`endif
        frames(4);
`ifdef KEYPAD_GHOST_REJECT_EN
        check("multi_held", kif.KEYHELD, 0);
`else
        check("multi_held", kif.KEYHELD, 1);
`endif
        keys = '0;
        frames(2);

        // Reset during PRESS_CHK with key held, then re-debounce
        keys = 16'h0200;
        frames(1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_presschk");
        rst = 1'b0;
        expect_press(4'h9);
        frames(3);
        check("after_rst1_held", kif.KEYHELD, 1);

        // Reset during HELD
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b0;
        expect_press(4'h9);
        frames(3);
        check("after_rst2_held", kif.KEYHELD, 1);
        check("after_rst2_code", kif.KEYCODE, 4'h9);
        keys = '0;
        frames(2);
        check("final_release", kif.KEYHELD, 0);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
